// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state type and one-bit full-adder functions
package serial_adder_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;
  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction
  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (y & z) | (x & z);
  endfunction
endpackage

// File: rtl/fa_bit.sv
// fa_bit: combinational one-bit full adder
module fa_bit
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = fa_sum(a, b, cin);
  assign cout = fa_carry(a, b, cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, LSB first, one full-adder cell
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("serial_adder: WIDTH must be in 2..64");
  end
  state_e state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic s, c, last;
  fa_bit u_fa (
    .a   (opa_q[0]),
    .b   (opb_q[0]),
    .cin (carry_q),
    .s   (s),
    .cout(c)
  );
  assign last = cnt_q == CNT_W'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    opa_d = opa_q;
    opb_d = opb_q;
    carry_d = carry_q;
    cnt_d = cnt_q;
    res_d = res_q;
    sum_d = sum_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        opa_d = a;
        opb_d = sub ? ~b : b;
        carry_d = cin ^ sub;
        cnt_d = '0;
        state_d = SHIFT;
      end
    end else begin
      opa_d = opa_q >> 1;
      opb_d = opb_q >> 1;
      res_d = {s, res_q[WIDTH-1:1]};
      carry_d = c;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        // ovf compares carry into the MSB (still in carry_q) with carry out of it
        sum_d = res_d;
        cout_d = c;
        ovf_d = carry_q ^ c;
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q <= '0;
      opb_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      sum_q <= sum_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign done = done_q;
  assign sum = sum_q;
  assign cout = cout_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, handshake corner cases and random ops vs arithmetic model
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin_i = 1'b0, sub_i = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic busy, done, cout, ovf;
  logic [W-1:0] sum;
  int checks = 0, errors = 0, cyc = 0, last_done_cyc = 0;
  logic [W-1:0] held_sum = '0;
  logic held_cout = 1'b0, held_ovf = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i), .cin(cin_i), .sub(sub_i),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W-1:0] s;
    logic co, ov;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference from integer arithmetic: unsigned range for carry, signed range for overflow
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb,
                       output logic [W-1:0] s, output logic co, output logic ov);
    longint ua = a, ub = b, uc = ci, r, sr;
    longint sa = $signed(a), sbv = $signed(b);
    if (!sb) begin
      r = ua + ub + uc;
      co = r >= (64'sd1 << W);
      sr = sa + sbv + uc;
    end else begin
      r = ua - ub - uc;
      co = ua >= ub + uc;
      sr = sa - sbv - uc;
    end
    s = r[W-1:0];
    ov = sr > ((64'sd1 << (W - 1)) - 1) || sr < -(64'sd1 << (W - 1));
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
    a_i = a; b_i = b; cin_i = ci; sub_i = sb; start = 1'b1;
    @(posedge clk); #1;
  endtask

  // Samples 1 time unit after each edge; n=0 is just after the start edge
  task automatic wait_done(input bit noise, output int n_done, output int busy_cnt, output int viol);
    n_done = -1; busy_cnt = 0; viol = 0;
    for (int n = 0; n <= W + 3 && n_done < 0; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      busy_cnt += int'(busy);
      if (done) begin
        n_done = n;
        last_done_cyc = cyc;
      end else if (sum !== held_sum || cout !== held_cout || ovf !== held_ovf) viol++;
      if (noise && (n == 3 || n == 7)) begin
        start = 1'b1; a_i = 8'hAA; b_i = 8'h55;
      end else start = 1'b0;
    end
  endtask

  task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                    input logic sb, input logic [W-1:0] es, input logic eco, input logic eov, input bit noise);
    int nd, bc, vi;
    launch(a, b, ci, sb);
    wait_done(noise, nd, bc, vi);
    chk({nm, " latency"}, nd, W);
    chk({nm, " busy_cycles"}, bc, W);
    chk({nm, " hold"}, vi, 0);
    chk({nm, " sum"}, sum, es);
    chk({nm, " cout"}, cout, eco);
    chk({nm, " ovf"}, ovf, eov);
    held_sum = es; held_cout = eco; held_ovf = eov;
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
  endtask

  initial begin
    vec_t tbl[7];
    logic [W-1:0] ra, rb, es;
    logic rc, rs, eco, eov;
    int nd, c1;
    tbl[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset ovf", ovf, 0);

    foreach (tbl[i]) begin
      op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
         tbl[i].s, tbl[i].co, tbl[i].ov, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d done_width", i), done, 0);
    end

    op("busy_prot", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1);
    count_dones(12, nd);
    chk("busy_prot extra_done", nd, 0);
    chk("busy_prot idle", busy, 0);

    op("b2b first", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
    c1 = last_done_cyc;
    op("b2b second", 8'h20, 8'h22, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0);
    chk("b2b gap", last_done_cyc - c1, W + 1);
    @(posedge clk); #1;

    launch(8'h11, 8'h22, 1'b0, 1'b0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst sum", sum, 0);
    chk("midrst cout", cout, 0);
    chk("midrst ovf", ovf, 0);
    count_dones(12, nd);
    chk("midrst no_done", nd, 0);
    held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
    op("post_rst", 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      model(ra, rb, rc, rs, es, eco, eov);
      op($sformatf("rnd%0d", i), ra, rb, rc, rs, es, eco, eov, 1'b0);
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial add/subtract unit: WIDTH-bit operands processed one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Start/busy/done handshake, subtract mode, carry-in/borrow-in, and carry-out plus signed-overflow flags.
- Used in area-constrained datapaths where WIDTH-bit parallel adders are too costly and latency of WIDTH cycles is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64; elaboration error outside range.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- cin  in  1  carry-in (add) / borrow-in (sub), captured on accepted start.
- sub  in  1  0: a+b+cin; 1: a-b-cin; captured on accepted start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when results update.
- sum  out  WIDTH  result, held until next done.
- cout  out  1  final carry out of the MSB; in sub mode, 1 = no borrow.
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1 at an edge): FSM to IDLE; busy, done, sum, cout, ovf, carry register, counter, and shift registers all 0. Reset mid-operation aborts silently; no done pulse.
- FSM states: IDLE and SHIFT. The done register is separate.
- IDLE: start=1 at edge E0 loads the shift registers.
  - opA <= a.
  - opB <= sub ? ~b : b.
  - carry <= cin ^ sub.
  - count <= 0.
  - FSM -> SHIFT.
- SHIFT, one bit per edge, bit i at edge E(i+1):
  - s = opA[0]^opB[0]^carry.
  - c = majority(opA[0], opB[0], carry).
  - opA and opB shift right.
  - s enters the result register at the MSB, shifting right.
  - carry <= c.
  - count++.
- Last bit (count == WIDTH-1) at edge E(WIDTH):
  - sum takes the complete result.
  - cout <= c.
  - ovf <= (carry before this edge) ^ c.
  - done <= 1.
  - FSM -> IDLE.
- Latency: done is high in the cycle after E(WIDTH), i.e. exactly WIDTH cycles after the start edge (8 for WIDTH=8).
- busy = (state == SHIFT): high for exactly WIDTH cycles, low in the done cycle.
- done is a single-cycle pulse; it deasserts at the next edge unconditionally.
- start while busy=1: ignored, with no effect on operands or results.
- start in the done cycle: accepted (busy=0). Back-to-back operations therefore have a throughput of one result per WIDTH+1 cycles.
- sum/cout/ovf change only on the done edge or on reset; they are stable otherwise, including throughout a subsequent operation.
- Inputs a, b, cin, sub are don't-care except at an accepting edge.
- Carry arithmetic is mod 2^WIDTH; wrap-around is reported via cout/ovf only.

Decomposition:
- Package serial_adder_pkg:
  - state typedef (IDLE, SHIFT).
  - sum and carry functions for one bit (x^y^z; (x&y)|(y&z)|(x&z)), reused by the cell.
- Sub-module fa_bit: combinational 1-bit full adder (a, b, cin -> s, cout) built on the package functions.
- serial_adder instantiates exactly one fa_bit. All sequencing, shifting and the carry flip-flop live in serial_adder.

Test Plan (WIDTH=8):
- Add, no overflow: a=0x35, b=0x4A, cin=0, sub=0 -> sum=0x7F, cout=0, ovf=0. busy high 8 cycles; done pulse 8 cycles after start edge, width 1.
- Add, wrap: 0x7F+0x01 -> 0x80, cout=0, ovf=1. Then 0xFF+0x01 -> 0x00, cout=1, ovf=0. Then 0xFF+0xFF with cin=1 -> 0xFF, cout=1, ovf=0.
- Subtract: 0x10-0x20 (sub=1, cin=0) -> 0xF0, cout=0 (borrow), ovf=0. 0x80-0x01 -> 0x7F, cout=1, ovf=1. 0x05-0x05 with cin=1 -> 0xFF, cout=0.
- Busy protection: start 0x01+0x02, then pulse start with a=0xAA, b=0x55 at cycles 3 and 7 -> result 0x03, exactly one done. Held sum stays unchanged during a following operation until its done.
- Back-to-back: start asserted in the done cycle with 0x20+0x22 -> accepted, second done 9 cycles after first done, sum=0x42.
- Reset mid-op: rst at cycle 4 of 0x11+0x22 -> next cycle busy=0, done=0, sum=0x00, cout=0, ovf=0, no done pulse. A new start after reset yields a correct result.
